wb_cpu_arb: RTL and testbench

WB_CPU_ARB -- requirements
Module: wb_cpu_arb

---
 rtl/wb_cpu_arb.sv | 182 ++++++++++++++++++
 tb/tb_wb_cpu_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cpu_arb.sv
// Two-master Wishbone arbiter for a CPU: master 0 is the instruction port,
// master 1 the data port. Round-robin on contention, grant held for the whole
// cyc, and a bus timeout that errors the owner and parks the bus in ABORT.
module wb_cpu_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [31:2] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [31:2] m1_addr_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [31:2] s_addr_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  input  logic        s_err_i
);

  // Counter wide enough to hold TIMEOUT; a 1-bit stub when the timeout is off.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The error fires in the stalled cycle whose count would reach TIMEOUT.
  localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LIM_C = CW'(LIM);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, ABORT = 2'd3} state_t;

  state_t        state, state_nxt;
  logic          own, own_nxt;     // master currently (or last) holding the bus
  logic          last, last_nxt;   // master that owned the bus most recently
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rst_sync;
  logic          granted, cur_cyc, cur_stb, stall, hit, pick;

  assign granted = (state == GNT0) || (state == GNT1);
  assign cur_cyc = own ? m1_cyc_i : m0_cyc_i;
  assign cur_stb = own ? m1_stb_i : m0_stb_i;
  assign stall   = granted && cur_cyc && cur_stb && !s_ack_i && !s_err_i;
  assign hit     = (TIMEOUT > 0) && stall && (cnt == LIM_C);
  assign pick    = (m0_cyc_i && m1_cyc_i) ? ~last : m1_cyc_i;

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  // Reset release synchroniser: arbitration is enabled from the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 1'b0;
    else        rst_sync <= 1'b1;
  end

  // State, ownership, round-robin pointer and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      own   <= 1'b0;
      last  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      own   <= own_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: grant decision, hold, release, timeout and abort exit.
  always_comb begin
    state_nxt = state;
    own_nxt   = own;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rst_sync && (m0_cyc_i || m1_cyc_i)) begin
          own_nxt   = pick;
          state_nxt = pick ? GNT1 : GNT0;
        end else begin
          state_nxt = IDLE;
        end
      end
      GNT0, GNT1: begin
        if (hit) begin
          state_nxt = ABORT;
          cnt_nxt   = '0;
        end else if (!cur_cyc) begin
          state_nxt = IDLE;
          last_nxt  = own;
          cnt_nxt   = '0;
        end else if (s_ack_i || s_err_i) begin
          cnt_nxt = '0;
        end else if (stall) begin
          cnt_nxt = cnt + CW'(1);
        end else begin
          cnt_nxt = cnt;
        end
      end
      ABORT: begin
        cnt_nxt = '0;
        if (!cur_cyc) begin
          state_nxt = IDLE;
          last_nxt  = own;
        end else begin
          state_nxt = ABORT;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: slave-side mux from the owner and ack/err routed back to it.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_addr_o = 30'd0;
    s_cti_o  = 3'd0;
    s_bte_o  = 2'd0;
    s_sel_o  = 4'd0;
    s_we_o   = 1'b0;
    s_data_o = 32'd0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      GNT0, GNT1: begin
        s_cyc_o = cur_cyc;
        s_stb_o = cur_stb;
        if (own) begin
          s_addr_o = m1_addr_i;
          s_cti_o  = m1_cti_i;
          s_bte_o  = m1_bte_i;
          s_sel_o  = m1_sel_i;
          s_we_o   = m1_we_i;
          s_data_o = m1_data_i;
          m1_ack_o = s_ack_i;
          m1_err_o = s_err_i | hit;
        end else begin
          s_addr_o = m0_addr_i;
          s_cti_o  = m0_cti_i;
          s_bte_o  = m0_bte_i;
          s_sel_o  = m0_sel_i;
          s_we_o   = m0_we_i;
          s_data_o = m0_data_i;
          m0_ack_o = s_ack_i;
          m0_err_o = s_err_i | hit;
        end
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_cpu_arb.sv
// Directed bench for wb_cpu_arb with TIMEOUT=8. Stimulus pushes expected
// master responses into a queue; a monitor pops one per observed ack/err.
module tb_wb_cpu_arb;

  localparam logic [3:0] F_M0ACK = 4'b1000;
  localparam logic [3:0] F_M0ERR = 4'b0100;
  localparam logic [3:0] F_M1ACK = 4'b0010;

  logic        clk, rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:2] m0_addr_i;
  logic [2:0]  m0_cti_i;
  logic [1:0]  m0_bte_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_data_i, m0_data_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:2] m1_addr_i;
  logic [2:0]  m1_cti_i;
  logic [1:0]  m1_bte_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_data_i, m1_data_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:2] s_addr_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_data_o, s_data_i;
  logic        s_ack_i, s_err_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [35:0] exp_q[$];

  wb_cpu_arb #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_addr_i(m0_addr_i),
    .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_addr_i(m1_addr_i),
    .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_addr_o(s_addr_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input logic [3:0] f, input logic [31:0] d);
    exp_q.push_back({f, d});
  endtask

  // Monitor: every cycle a master sees ack or err must match the next expectation.
  always @(negedge clk) begin
    logic [3:0]  act_f;
    logic [31:0] act_d;
    logic [35:0] e;
    act_f = {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
    if (act_f != 4'b0000) begin
      act_d = (m1_ack_o || m1_err_o) ? m1_data_o : m0_data_o;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got flags %b data %h expected none (t=%0t)", act_f, act_d, $time);
      end else begin
        e = exp_q.pop_front();
        if ({act_f, act_d} !== e) begin
          n_fail++;
          $display("FAIL rsp: got flags %b data %h expected flags %b data %h (t=%0t)",
                   act_f, act_d, e[35:32], e[31:0], $time);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 30'h0000_0111;
    m0_cti_i = 3'd0; m0_bte_i = 2'd0; m0_sel_i = 4'hF; m0_data_i = 32'h1111_0000;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 30'h0000_0222;
    m1_cti_i = 3'd0; m1_bte_i = 2'd0; m1_sel_i = 4'hF; m1_data_i = 32'h2222_0000;
    s_data_i = 32'd0; s_ack_i = 1'b0; s_err_i = 1'b0;

    // Reset holds the slave side quiet even with both masters requesting.
    tick(); tick();
    @(negedge clk);
    chk("rst_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_we", 32'(s_we_o), 32'd0);
    tick();

    // Release with both requesting: idle on edge 1, m1 granted on edge 2.
    m0_we_i = 1'b0;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rel_edge1_idle", 32'(s_cyc_o), 32'd0);
    tick();
    s_ack_i = 1'b1; s_data_i = 32'hA1A1_0001;
    expect_rsp(F_M1ACK, 32'hA1A1_0001);
    @(negedge clk);
    chk("rr_first_cyc", 32'(s_cyc_o), 32'd1);
    chk("rr_first_m1", 32'(s_addr_o), 32'h0000_0222);
    tick();
    s_ack_i = 1'b0; s_data_i = 32'd0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_gap", 32'(s_cyc_o), 32'd0);
    tick();
    @(negedge clk);
    chk("m0_after_gap_cyc", 32'(s_cyc_o), 32'd1);
    chk("m0_after_gap_addr", 32'(s_addr_o), 32'h0000_0111);
    tick();
    s_ack_i = 1'b1; s_data_i = 32'hA0A0_0002;
    expect_rsp(F_M0ACK, 32'hA0A0_0002);
    tick();
    s_ack_i = 1'b0; s_data_i = 32'd0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();

    // m0 single read at 0x1000, ack two cycles after stb.
    m0_addr_i = 30'h0000_0400; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0;
    tick();
    @(negedge clk);
    chk("rd_addr", 32'(s_addr_o), 32'h0000_0400);
    chk("rd_we", 32'(s_we_o), 32'd0);
    tick(); tick();
    s_ack_i = 1'b1; s_data_i = 32'hCAFE_0028;
    expect_rsp(F_M0ACK, 32'hCAFE_0028);
    @(negedge clk);
    chk("m1_data_follows", m1_data_o, 32'hCAFE_0028);
    tick();
    s_ack_i = 1'b0; s_data_i = 32'd0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();

    // m1 4-beat incrementing burst while m0 waits.
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010; m1_addr_i = 30'h0000_0800;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 30'h0000_0123;
    tick();
    for (int b = 0; b < 4; b++) begin
      m1_cti_i  = (b == 3) ? 3'b111 : 3'b010;
      m1_addr_i = 30'h0000_0800 + 30'(b);
      s_ack_i = 1'b1; s_data_i = 32'hB000_0000 + 32'(b);
      expect_rsp(F_M1ACK, 32'hB000_0000 + 32'(b));
      @(negedge clk);
      chk("burst_cti", 32'(s_cti_o), (b == 3) ? 32'd7 : 32'd2);
      chk("burst_addr", 32'(s_addr_o), 32'h0000_0800 + 32'(b));
      tick();
    end
    s_ack_i = 1'b0; s_data_i = 32'd0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cti_i = 3'd0;
    tick();
    @(negedge clk);
    chk("burst_gap", 32'(s_cyc_o), 32'd0);

    // m0 now granted; slave never answers, so the 8th stalled cycle errors.
    tick();
    expect_rsp(F_M0ERR, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) chk("to_grant_addr", 32'(s_addr_o), 32'h0000_0123);
      chk("to_err_cycle", 32'(m0_err_o), (k == 8) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clk);
    chk("abort_cyc", 32'(s_cyc_o), 32'd0);
    chk("abort_stb", 32'(s_stb_o), 32'd0);
    tick();
    s_ack_i = 1'b1;
    tick();
    s_ack_i = 1'b0;
    @(negedge clk);
    chk("abort_hold", 32'(s_cyc_o), 32'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();

    // Ack on the timeout cycle wins, then the next stall counts from zero.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 30'h0000_0200;
    tick();
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) begin
        s_ack_i = 1'b1; s_data_i = 32'hE0E0_0033;
        expect_rsp(F_M0ACK, 32'hE0E0_0033);
      end
      @(negedge clk);
      chk("race_no_err", 32'(m0_err_o), 32'd0);
      tick();
    end
    s_ack_i = 1'b0; s_data_i = 32'd0;
    expect_rsp(F_M0ERR, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("recount_err", 32'(m0_err_o), (k == 8) ? 32'd1 : 32'd0);
      tick();
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();

    // Asynchronous reset while m1 waits for its write ack.
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 30'h0000_0300;
    m1_data_i = 32'h5A5A_0032;
    tick();
    @(negedge clk);
    chk("wr_we", 32'(s_we_o), 32'd1);
    chk("wr_data", s_data_o, 32'h5A5A_0032);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(s_cyc_o), 32'd0);
    chk("async_rst_we", 32'(s_we_o), 32'd0);
    s_ack_i = 1'b1; s_data_i = 32'hDEAD_0001;
    tick(); tick();
    s_ack_i = 1'b0; s_data_i = 32'd0;
    rst_n = 1'b1;
    m1_we_i = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 30'h0000_0111;
    tick();
    @(negedge clk);
    chk("rst2_edge1_idle", 32'(s_cyc_o), 32'd0);
    tick();
    @(negedge clk);
    chk("rst2_cyc", 32'(s_cyc_o), 32'd1);
    chk("rst2_m1_first", 32'(s_addr_o), 32'h0000_0300);
    tick();
    s_ack_i = 1'b1; s_data_i = 32'h7777_0032;
    expect_rsp(F_M1ACK, 32'h7777_0032);
    tick();
    s_ack_i = 1'b0; s_data_i = 32'd0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick(); tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
